// File: rtl/result_pager.sv
// Latches a result word and pages it, one byte per page, onto two seven-segment
// digits from the highest non-zero byte down to byte 0, with a blank gap before each page.
module result_pager #(
    parameter int RESULT_WIDTH = 64,
    parameter int DWELL_CYCLES = 25_000_000,
    parameter int BLANK_CYCLES = 2_500_000
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    result_valid,
    input  logic [RESULT_WIDTH-1:0] result,
    output logic [6:0]              ss1_A_G,
    output logic [6:0]              ss2_A_G,
    output logic [3:0]              page_led,
    output logic                    busy
);

    localparam int NPAGES  = RESULT_WIDTH / 8;
    localparam int PAGE_W  = (NPAGES > 1) ? $clog2(NPAGES) : 1;
    localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [6:0]       SEG_DASH   = 7'h7E;
    localparam logic [6:0]       SEG_OFF    = 7'h7F;

    typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic [RESULT_WIDTH-1:0] word;
    logic [PAGE_W-1:0]       top;
    logic [PAGE_W-1:0]       page;

    logic [PAGE_W-1:0]       top_in;
    logic [PAGE_W-1:0]       next_page;
    logic [7:0]              cur_byte;
    logic [7:0]              nxt_byte;
    logic [7:0]              new_byte;

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: glyph = 7'h01;
            4'h1: glyph = 7'h4F;
            4'h2: glyph = 7'h12;
            4'h3: glyph = 7'h06;
            4'h4: glyph = 7'h4C;
            4'h5: glyph = 7'h24;
            4'h6: glyph = 7'h20;
            4'h7: glyph = 7'h0F;
            4'h8: glyph = 7'h00;
            4'h9: glyph = 7'h04;
            4'hA: glyph = 7'h08;
            4'hB: glyph = 7'h60;
            4'hC: glyph = 7'h31;
            4'hD: glyph = 7'h42;
            4'hE: glyph = 7'h30;
            default: glyph = 7'h38;
        endcase
    endfunction

    function automatic logic [7:0] byte_at(input logic [RESULT_WIDTH-1:0] w,
                                           input logic [PAGE_W-1:0] pg);
        byte_at = w[pg*8 +: 8];
    endfunction

    // Highest non-zero byte wins; an all-zero word leaves top at 0.
    always_comb begin
        top_in = '0;
        for (int i = 1; i < NPAGES; i++) begin
            if (result[i*8 +: 8] != 8'h00) top_in = PAGE_W'(i);
        end
    end

    assign next_page = (page == '0) ? top : page - 1'b1;
    assign cur_byte  = byte_at(word, page);
    assign nxt_byte  = byte_at(word, next_page);
    assign new_byte  = byte_at(result, top_in);

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            word     <= '0;
            top      <= '0;
            page     <= '0;
            ss1_A_G  <= SEG_DASH;
            ss2_A_G  <= SEG_DASH;
            page_led <= 4'h0;
            busy     <= 1'b0;
        end else if (result_valid) begin
            // A new result overrides whatever page is in progress.
            word     <= result;
            top      <= top_in;
            page     <= top_in;
            cnt      <= '0;
            busy     <= 1'b1;
            page_led <= 4'(top_in);
            if (BLANK_CYCLES == 0) begin
                state   <= SHOW;
                ss1_A_G <= glyph(new_byte[7:4]);
                ss2_A_G <= glyph(new_byte[3:0]);
            end else begin
                state   <= BLANK;
                ss1_A_G <= SEG_OFF;
                ss2_A_G <= SEG_OFF;
            end
        end else begin
            case (state)
                BLANK: begin
                    if (cnt == BLANK_LAST) begin
                        cnt     <= '0;
                        state   <= SHOW;
                        ss1_A_G <= glyph(cur_byte[7:4]);
                        ss2_A_G <= glyph(cur_byte[3:0]);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SHOW: begin
                    if (cnt == DWELL_LAST) begin
                        cnt      <= '0;
                        page     <= next_page;
                        page_led <= 4'(next_page);
                        if (BLANK_CYCLES == 0) begin
                            state   <= SHOW;
                            ss1_A_G <= glyph(nxt_byte[7:4]);
                            ss2_A_G <= glyph(nxt_byte[3:0]);
                        end else begin
                            state   <= BLANK;
                            ss1_A_G <= SEG_OFF;
                            ss2_A_G <= SEG_OFF;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_result_pager.sv
// Randomized self-checking bench for result_pager against a closed-form page-schedule model.
module tb_result_pager;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        rv1 = 1'b0;
    logic [31:0] res1 = '0;
    logic [6:0]  a1, b1;
    logic [3:0]  led1;
    logic        busy1;
    logic        rv2 = 1'b0;
    logic [31:0] res2 = '0;
    logic [6:0]  a2, b2;
    logic [3:0]  led2;
    logic        busy2;

    int checks = 0;
    int errors = 0;

    logic [6:0] glyph_tab [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                                   7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

    result_pager #(.RESULT_WIDTH(32), .DWELL_CYCLES(4), .BLANK_CYCLES(2)) dut1 (
        .clock(clock), .reset(reset), .result_valid(rv1), .result(res1),
        .ss1_A_G(a1), .ss2_A_G(b1), .page_led(led1), .busy(busy1));

    result_pager #(.RESULT_WIDTH(32), .DWELL_CYCLES(4), .BLANK_CYCLES(0)) dut2 (
        .clock(clock), .reset(reset), .result_valid(rv2), .result(res2),
        .ss1_A_G(a2), .ss2_A_G(b2), .page_led(led2), .busy(busy2));

    always #5 clock = ~clock;

    // Expected {ss1, ss2, led, busy} k cycles after the strobe cycle (k >= 1).
    function automatic logic [18:0] model(input logic [31:0] w, input int k, input int blank);
        int top, period, idx, phase, pg;
        logic [7:0] by;
        top = 0;
        for (int i = 0; i < 4; i++) if (w[8*i +: 8] != 8'h00) top = i;
        period = blank + 4;
        idx    = ((k - 1) / period) % (top + 1);
        phase  = (k - 1) % period;
        pg     = top - idx;
        by     = w[8*pg +: 8];
        if (phase < blank) model = {7'h7F, 7'h7F, 4'(pg), 1'b1};
        else model = {glyph_tab[by[7:4]], glyph_tab[by[3:0]], 4'(pg), 1'b1};
    endfunction

    task automatic strobe1(input logic [31:0] w);
        rv1 = 1'b1; res1 = w;
        @(negedge clock);
        rv1 = 1'b0; res1 = $urandom;
    endtask

    task automatic strobe2(input logic [31:0] w);
        rv2 = 1'b1; res2 = w;
        @(negedge clock);
        rv2 = 1'b0; res2 = $urandom;
    endtask

    task automatic test_reset();
        logic [18:0] exp_v = {7'h7E, 7'h7E, 4'h0, 1'b0};
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            res1 = $urandom; res2 = $urandom;
            checks++;
            if ({a1, b1, led1, busy1} !== exp_v) begin
                errors++;
                $display("FAIL reset1 c=%0d got %h exp %h", c, {a1, b1, led1, busy1}, exp_v);
            end
            checks++;
            if ({a2, b2, led2, busy2} !== exp_v) begin
                errors++;
                $display("FAIL reset2 c=%0d got %h exp %h", c, {a2, b2, led2, busy2}, exp_v);
            end
            @(negedge clock);
        end
    endtask

    task automatic test_leading_zero();
        logic [31:0] w = 32'h0012AB34;
        logic [18:0] exp_v;
        strobe1(w);
        for (int k = 1; k <= 22; k++) begin
            exp_v = model(w, k, 2);
            checks++;
            if ({a1, b1, led1, busy1} !== exp_v) begin
                errors++;
                $display("FAIL leading_zero k=%0d got %h exp %h", k, {a1, b1, led1, busy1}, exp_v);
            end
            if (k == 3) begin
                checks++;
                if ({a1, b1, led1} !== {7'h4F, 7'h12, 4'd2}) begin
                    errors++;
                    $display("FAIL leading_zero_first got %h exp %h", {a1, b1, led1}, {7'h4F, 7'h12, 4'd2});
                end
            end
            @(negedge clock);
        end
    endtask

    task automatic test_all_zero();
        logic [18:0] exp_v;
        strobe1(32'h0);
        for (int k = 1; k <= 14; k++) begin
            exp_v = model(32'h0, k, 2);
            checks++;
            if ({a1, b1, led1, busy1} !== exp_v) begin
                errors++;
                $display("FAIL all_zero k=%0d got %h exp %h", k, {a1, b1, led1, busy1}, exp_v);
            end
            @(negedge clock);
        end
    endtask

    task automatic test_override();
        logic [18:0] exp_v;
        strobe1(32'hFFFFFFFF);
        for (int k = 1; k <= 4; k++) begin
            exp_v = model(32'hFFFFFFFF, k, 2);
            checks++;
            if ({a1, b1, led1, busy1} !== exp_v) begin
                errors++;
                $display("FAIL override_pre k=%0d got %h exp %h", k, {a1, b1, led1, busy1}, exp_v);
            end
            if (k < 4) @(negedge clock);
        end
        strobe1(32'h0000000E);
        for (int k = 1; k <= 8; k++) begin
            exp_v = model(32'h0000000E, k, 2);
            checks++;
            if ({a1, b1, led1, busy1} !== exp_v) begin
                errors++;
                $display("FAIL override_mid k=%0d got %h exp %h", k, {a1, b1, led1, busy1}, exp_v);
            end
            @(negedge clock);
        end
        strobe1(32'h00A50000);
        for (int k = 1; k <= 6; k++) begin
            if (k == 6) begin
                checks++;
                if ({a1, b1, led1} !== {7'h08, 7'h24, 4'd2}) begin
                    errors++;
                    $display("FAIL override_lastshow got %h exp %h", {a1, b1, led1}, {7'h08, 7'h24, 4'd2});
                end
            end else begin
                @(negedge clock);
            end
        end
        strobe1(32'h3C000000);
        for (int k = 1; k <= 12; k++) begin
            exp_v = model(32'h3C000000, k, 2);
            checks++;
            if ({a1, b1, led1, busy1} !== exp_v) begin
                errors++;
                $display("FAIL override_last k=%0d got %h exp %h", k, {a1, b1, led1, busy1}, exp_v);
            end
            @(negedge clock);
        end
    endtask

    task automatic test_random();
        logic [31:0] w;
        logic [18:0] exp_v;
        int n;
        for (int it = 0; it < 8; it++) begin
            w = $urandom;
            for (int i = 0; i < 4; i++) if ($urandom_range(0, 2) == 0) w[8*i +: 8] = 8'h00;
            n = $urandom_range(1, 30);
            strobe1(w);
            for (int k = 1; k <= n; k++) begin
                exp_v = model(w, k, 2);
                checks++;
                if ({a1, b1, led1, busy1} !== exp_v) begin
                    errors++;
                    $display("FAIL random w=%h k=%0d got %h exp %h", w, k, {a1, b1, led1, busy1}, exp_v);
                end
                @(negedge clock);
            end
        end
    endtask

    task automatic test_zero_gap();
        logic [18:0] exp_v;
        strobe2(32'h0000C0DE);
        for (int k = 1; k <= 12; k++) begin
            exp_v = model(32'h0000C0DE, k, 0);
            checks++;
            if ({a2, b2, led2, busy2} !== exp_v) begin
                errors++;
                $display("FAIL zero_gap k=%0d got %h exp %h", k, {a2, b2, led2, busy2}, exp_v);
            end
            if (k == 5) begin
                checks++;
                if ({a2, b2, led2} !== {7'h42, 7'h30, 4'd0}) begin
                    errors++;
                    $display("FAIL zero_gap_page0 got %h exp %h", {a2, b2, led2}, {7'h42, 7'h30, 4'd0});
                end
            end
            @(negedge clock);
        end
    endtask

    task automatic test_reset_mid();
        logic [18:0] exp_v;
        logic [18:0] idle_v = {7'h7E, 7'h7E, 4'h0, 1'b0};
        strobe1(32'h00005A3C);
        for (int k = 1; k <= 4; k++) begin
            exp_v = model(32'h00005A3C, k, 2);
            checks++;
            if ({a1, b1, led1, busy1} !== exp_v) begin
                errors++;
                $display("FAIL reset_mid_pre k=%0d got %h exp %h", k, {a1, b1, led1, busy1}, exp_v);
            end
            if (k < 4) @(negedge clock);
        end
        reset = 1'b1; rv1 = 1'b1; res1 = 32'h12345678;
        @(negedge clock);
        reset = 1'b0; rv1 = 1'b0;
        for (int c = 0; c < 6; c++) begin
            checks++;
            if ({a1, b1, led1, busy1} !== idle_v) begin
                errors++;
                $display("FAIL reset_mid c=%0d got %h exp %h", c, {a1, b1, led1, busy1}, idle_v);
            end
            @(negedge clock);
        end
    endtask

    initial begin
        @(negedge clock);
        test_reset();
        test_leading_zero();
        test_all_zero();
        test_override();
        test_random();
        test_zero_gap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/result_pager.md
# result_pager

Display scheduler between `solution` and the two seven-segment digits and four LEDs on the board. It latches a wide result word and time-multiplexes it onto the two-digit display one byte (two hex digits) at a time, from the most significant non-zero byte down to byte 0, then wraps. Each page is preceded by a blank gap so repeated bytes read as distinct pages. The LEDs show the index of the current page.

## Interface

- `RESULT_WIDTH`, 64: width of the result word; a multiple of 8, from 8 to 128. NPAGES = RESULT_WIDTH/8.
- `DWELL_CYCLES`, 25_000_000: number of cycles each page is shown; must be at least 1.
- `BLANK_CYCLES`, 2_500_000: number of blank cycles before each page; 0 disables the gap.
- `clock`  in  1  system clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `result_valid`  in  1  one-cycle strobe; `result` is sampled on a cycle where this is high.
- `result`  in  RESULT_WIDTH  result word to display.
- `ss1_A_G`  out  7  left digit, high nibble of the current byte; active-low; bit 6 = A … bit 0 = G.
- `ss2_A_G`  out  7  right digit, low nibble of the current byte; same encoding as `ss1_A_G`.
- `page_led`  out  4  binary index of the current page (byte 0 = LSB byte); active-high.
- `busy`  out  1  high whenever a result is latched (any state other than IDLE).

## Operation

- States: IDLE, BLANK, SHOW.
- Reset (synchronous; takes effect on any cycle, including mid-page):
  - state = IDLE, counter = 0, latched word = 0.
  - `ss1_A_G` = `ss2_A_G` = 7'h7E (dash, G lit).
  - `page_led` = 0, `busy` = 0.
- IDLE:
  - Both digits show a dash; LEDs are 0.
  - On `result_valid`: latch `result` and set top = index of the highest non-zero byte (0 if the word is all zero).
  - Then set page = top and go to BLANK (or directly to SHOW if BLANK_CYCLES = 0).
- BLANK:
  - Segments are all off (7'h7F); `page_led` = page.
  - Stays for exactly BLANK_CYCLES cycles, then goes to SHOW.
- SHOW:
  - `ss1_A_G` = glyph(byte[page][7:4]); `ss2_A_G` = glyph(byte[page][3:0]); `page_led` = page.
  - Stays for exactly DWELL_CYCLES cycles.
  - Then: if page = 0, page = top; otherwise page = page − 1. Next state is BLANK (or SHOW if BLANK_CYCLES = 0).
- When top = 0, a single page alternates between BLANK and SHOW indefinitely.
- A new `result_valid` in BLANK or SHOW takes priority over everything:
  - Relatch the word, recompute top, clear the counter, set page = new top.
  - Enter BLANK (or SHOW if BLANK_CYCLES = 0).
- No result is dropped, and there is no way back to IDLE except reset.
- Glyphs use standard hex, active-low, in A..G order:
  - 0=7'h01, 1=7'h4F, 2=7'h12, 3=7'h06, 4=7'h4C, 5=7'h24, 6=7'h20, 7=7'h0F
  - 8=7'h00, 9=7'h04, A=7'h08, b=7'h60, C=7'h31, d=7'h42, E=7'h30, F=7'h38
- Dwell counter:
  - Width is clog2(max(DWELL_CYCLES, BLANK_CYCLES)+1).
  - Compare against count−1; the counter never wraps.
- Top-byte search is combinational on `result`, priority from MSB down, and registered together with the word.
- `page_led` shows page[3:0]. For NPAGES > 16 the upper page bits are not shown.

## Timing

- All outputs are registered, with no combinational path from input to output.
- Latency: `result_valid` high in cycle N → BLANK outputs (segments 7'h7F, `page_led` = top, `busy` = 1) visible in cycle N+1.
- The first page's glyphs appear in cycle N+1+BLANK_CYCLES.
- Page period is exactly BLANK_CYCLES + DWELL_CYCLES cycles.
- `result_valid` in the same cycle as the last SHOW cycle: the new result wins, and the next cycle is BLANK of the new top, not the old page's successor.
- `result_valid` and `reset` high together: reset wins, and the result is discarded.
- `result` is ignored in cycles where `result_valid` is low.

## Test plan

Bench parameters for all scenarios: RESULT_WIDTH=32, DWELL_CYCLES=4, BLANK_CYCLES=2.

- **Reset:** assert `reset` 2 cycles → `ss1_A_G` = `ss2_A_G` = 7'h7E, `page_led` = 0, `busy` = 0, held until the first `result_valid`.
- **Leading-zero skip:** strobe `result` = 32'h0012AB34 at cycle 10.
  - Cycles 11–12: blank with `page_led` = 2.
  - Cycles 13–16: 7'h4F / 7'h12 (page 2).
  - Cycles 17–18: blank, then 7'h08 / 7'h60 (page 1).
  - Then 7'h06 / 7'h4C (page 0).
  - Then back to page 2.
- **All zero:** `result` = 0 → only page 0 shown as 7'h01 / 7'h01, alternating blank (2 cycles) and show (4 cycles), `page_led` = 0 throughout.
- **Mid-page override:** `result` = 32'hFFFFFFFF, then `result` = 32'h0000000E strobed on the 2nd SHOW cycle of page 3 → next cycle is blank with `page_led` = 0, then 7'h01 / 7'h30.
- **Zero gap:** BLANK_CYCLES=0, `result` = 32'h0000C0DE → page 1 (7'h31 / 7'h01) for 4 cycles, then page 0 (7'h42 / 7'h30) for 4 cycles, with no off cycles.
- **Reset mid-operation:** `reset` during SHOW of page 1 → next cycle shows dashes, LEDs 0, `busy` 0; `result_valid` in the same cycle as `reset` is ignored.
